// File: rtl/bit_reverse_pipe.sv
// bit_reverse_pipe: multi-lane bit-permutation engine with valid/ready
// handshaking and a two-entry (output register + skid register) buffer.
// Each lane is transformed at accept time according to in_mode:
//   00 pass-through, 01 full reverse, 10 group-order reverse,
//   11 in-group bit reverse.
// Optional feature macro: BITREV_PARITY_EN adds the out_parity port, a
// per-lane even parity of the transformed word that travels with its data.
module bit_reverse_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            xfer_cnt
`ifdef BITREV_PARITY_EN
  ,
  output logic [LANES-1:0]       out_parity
`endif
);

  localparam int LW = LANES * WIDTH;
  localparam int NG = WIDTH / GROUP;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Per-lane permutation: for every output bit, pick the source bit.
  function automatic logic [WIDTH-1:0] f_xform(input logic [1:0]       mode,
                                                input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] o;
    logic [IW-1:0]    src;
    int               g;
    int               j;
    o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g = i / GROUP;
      j = i % GROUP;
      case (mode)
        2'b00:   src = IW'(i);
        2'b01:   src = IW'(WIDTH - 1 - i);
        2'b10:   src = IW'((NG - 1 - g) * GROUP + j);
        default: src = IW'(g * GROUP + GROUP - 1 - j);
      endcase
      o[i] = w[src];
    end
    return o;
  endfunction

  logic          r_or_valid;
  logic [LW-1:0] r_or_data;
  logic          r_sr_valid;
  logic [LW-1:0] r_sr_data;
  logic          r_in_ready;
  logic [15:0]   r_xfer_cnt;

  logic [LW-1:0] w_xform;
  logic          w_acc;
  logic          w_drain;
  logic          w_or_free;
  logic          w_or_from_sr;
  logic          w_or_from_in;
  logic          w_sr_load;
  logic          w_sr_valid_nxt;
  logic          w_or_valid_nxt;

  // Transform every lane of the incoming beat with the beat's mode.
  always_comb begin
    w_xform = '0;
    for (int k = 0; k < LANES; k++) begin
      w_xform[k*WIDTH +: WIDTH] = f_xform(in_mode, in_data[k*WIDTH +: WIDTH]);
    end
  end

  // Buffer steering: OR refills from SR first, otherwise from the input;
  // anything accepted while OR stays occupied goes to SR.
  always_comb begin
    w_acc          = in_valid & r_in_ready;
    w_drain        = r_or_valid & out_ready;
    w_or_free      = ~r_or_valid | out_ready;
    w_or_from_sr   = w_or_free & r_sr_valid;
    w_or_from_in   = w_or_free & ~r_sr_valid & w_acc;
    w_sr_load      = w_acc & ~w_or_from_in;
    w_sr_valid_nxt = w_sr_load | (r_sr_valid & ~w_or_from_sr);
    w_or_valid_nxt = w_or_from_sr | w_or_from_in | ~w_or_free;
  end

  // Storage, handshake and transfer counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_sr_valid <= 1'b0;
      r_sr_data  <= '0;
      r_in_ready <= 1'b0;
      r_xfer_cnt <= 16'h0000;
    end else begin
      r_or_valid <= w_or_valid_nxt;
      r_sr_valid <= w_sr_valid_nxt;
      r_in_ready <= ~w_sr_valid_nxt;
      if (w_or_from_sr) begin
        r_or_data <= r_sr_data;
      end else if (w_or_from_in) begin
        r_or_data <= w_xform;
      end
      if (w_sr_load) begin
        r_sr_data <= w_xform;
      end
      if (w_drain) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

`ifdef BITREV_PARITY_EN
  logic [LANES-1:0] w_par;
  logic [LANES-1:0] r_or_par;
  logic [LANES-1:0] r_sr_par;

  // Even parity of each transformed lane.
  always_comb begin
    w_par = '0;
    for (int k = 0; k < LANES; k++) begin
      w_par[k] = ^w_xform[k*WIDTH +: WIDTH];
    end
  end

  // Parity follows exactly the same path through OR/SR as its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_or_par <= '0;
      r_sr_par <= '0;
    end else begin
      if (w_or_from_sr) begin
        r_or_par <= r_sr_par;
      end else if (w_or_from_in) begin
        r_or_par <= w_par;
      end
      if (w_sr_load) begin
        r_sr_par <= w_par;
      end
    end
  end

  assign out_parity = r_or_par;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_valid;
  assign out_data  = r_or_data;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_bit_reverse_pipe.sv
// Scoreboard bench for bit_reverse_pipe: a driver pushes the expected
// transformed beat for every accepted input, an independent monitor pops and
// compares whenever the DUT presents a beat.
module tb_bit_reverse_pipe;

  localparam int W  = 8;
  localparam int GP = 4;
  localparam int L  = 2;
  localparam int NG = W / GP;
  localparam int LW = L * W;

  typedef struct {
    logic [LW-1:0] d;
    logic [L-1:0]  p;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [LW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic [15:0]   xfer_cnt;
`ifdef BITREV_PARITY_EN
  logic [L-1:0]  out_parity;
`endif

  int   n_err;
  int   n_checks;
  exp_t sb[$];
  exp_t m_exp;

  bit_reverse_pipe #(.WIDTH(W), .GROUP(GP), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
`ifdef BITREV_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: works on lane values as integers and groups as an array.
  function automatic exp_t model(input logic [1:0] m, input logic [LW-1:0] d);
    exp_t e;
    int   w;
    int   r;
    int   grp[NG];
    e.d = '0;
    e.p = '0;
    for (int k = 0; k < L; k++) begin
      w = int'(d[k*W +: W]);
      for (int g = 0; g < NG; g++) grp[g] = (w >> (g * GP)) % (1 << GP);
      r = 0;
      case (m)
        2'b00: r = w;
        2'b01: for (int i = 0; i < W; i++) r += ((w >> i) % 2) << (W - 1 - i);
        2'b10: for (int g = 0; g < NG; g++) r += grp[NG - 1 - g] << (g * GP);
        default:
          for (int g = 0; g < NG; g++)
            for (int j = 0; j < GP; j++)
              r += ((grp[g] >> j) % 2) << (g * GP + GP - 1 - j);
      endcase
      e.d[k*W +: W] = r[W-1:0];
      e.p[k]        = ^r[W-1:0];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle and records an accept.
  task automatic drive(input bit v, input logic [1:0] m, input logic [LW-1:0] d,
                       output bit acc);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
    acc = v && (in_ready === 1'b1) && (rst_n === 1'b1);
    if (acc) sb.push_back(model(m, d));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, a);
  endtask

  task automatic drain_all();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    idle(1);
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // Monitor: every presented beat must match the head of the scoreboard;
  // it is popped only when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL stale_beat: out_data=%h with no beat expected", out_data);
      end else begin
        m_exp = sb[0];
        if (out_data !== m_exp.d) begin
          n_err++;
          $display("FAIL out_data: got %h, expected %h", out_data, m_exp.d);
        end
`ifdef BITREV_PARITY_EN
        if (out_parity !== m_exp.p) begin
          n_err++;
          $display("FAIL out_parity: got %b, expected %b", out_parity, m_exp.p);
        end
`endif
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit   a;
    int   tries;
    exp_t ea;
    n_err     = 0;
    n_checks  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
`ifdef BITREV_PARITY_EN
    chk("rst_out_parity", out_parity, 0);
`endif

    rst_n = 1'b1;
    idle(1);
    chk("ready_after_release", in_ready, 1);

    // Directed transforms with the consumer always ready.
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 16'h0F01, a);
    chk("mode01_valid", out_valid, 1);
    chk("mode01_data", out_data, 16'hF080);
    drive(1'b1, 2'b00, 16'h0F01, a);
    chk("mode00_data", out_data, 16'h0F01);
    drive(1'b1, 2'b10, 16'h1A1A, a);
    chk("mode10_data", out_data, 16'hA1A1);
    drive(1'b1, 2'b11, 16'h1A1A, a);
    chk("mode11_data", out_data, 16'h8585);
    drive(1'b1, 2'b01, 16'h0301, a);
    chk("mode01_lanes", out_data, 16'hC080);
`ifdef BITREV_PARITY_EN
    chk("parity_0301", out_parity, 2'b01);
`endif
    drain_all();
    chk("xfer_after_directed", xfer_cnt, 5);

    // Backpressure: A and B fill OR and SR, C must wait.
    do_reset();
    out_ready = 1'b0;
    ea = model(2'b01, 16'h1234);
    drive(1'b1, 2'b01, 16'h1234, a);
    chk("bp_acc_a", a, 1);
    drive(1'b1, 2'b10, 16'h5678, a);
    chk("bp_acc_b", a, 1);
    chk("bp_ready_low", in_ready, 0);
    drive(1'b1, 2'b11, 16'h9ABC, a);
    chk("bp_c_refused", a, 0);
    chk("bp_hold_a", out_data, ea.d);
    out_ready = 1'b1;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 10) begin
      drive(1'b1, 2'b11, 16'h9ABC, a);
      tries++;
    end
    chk("bp_ready_rise", tries, 2);
    in_valid = 1'b0;
    drain_all();
    chk("bp_xfer_cnt", xfer_cnt, 3);

    // Reset with both entries full: nothing stale may appear afterwards.
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'hDEAD, a);
    drive(1'b1, 2'b01, 16'hBEEF, a);
    chk("mid_full_ready", in_ready, 0);
    rst_n = 1'b0;
    sb.delete();
    idle(1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_xfer_cnt", xfer_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    idle(1);
    chk("mid_release_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(4);
    chk("mid_no_stale", out_valid, 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(3) != 0);
      drive($urandom_range(1) == 1, 2'($urandom_range(3)), LW'($urandom), a);
    end
    in_valid = 1'b0;
    drain_all();

    // Counter wrap: 65537 drained beats leave xfer_cnt at 1.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 2'($urandom_range(3)), LW'($urandom), a);
    end
    in_valid = 1'b0;
    drain_all();
    chk("xfer_wrap", xfer_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
